// File: rtl/axi_eth_pkg.sv
// Shared types for the 10GbE MAC loopback endpoint.
// Buffer word layout and FSM state encodings.
package axi_eth_pkg;

  localparam int WORD_W   = 74;
  localparam int DATA_LSB = 0;
  localparam int KEEP_LSB = 64;
  localparam int LAST_BIT = 72;
  localparam int GOOD_BIT = 73;

  typedef struct packed {
    logic        good;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } lpbk_word_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RECV = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_SEND = 2'd1
  } rd_state_e;

endpackage

// File: rtl/axi_eth_lpbk_ram.sv
// Simple dual-port frame buffer RAM for the MAC loopback.
// Read data is registered and holds while re is low.
module axi_eth_lpbk_ram
  import axi_eth_pkg::*;
#(
  parameter int AW = 9,
  parameter int W  = WORD_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_eth_mac_lpbk.sv
// MAC-side loopback: store whole TX frames, replay them on RX.
// AXI_ETH_LPBK_STATS_EN enables the saturating stats counters.
module axi_eth_mac_lpbk
  import axi_eth_pkg::*;
#(
  parameter string C_FAMILY     = "",
  parameter int    C_DEPTH_LOG2 = 9,
  parameter int    C_DROP_BAD   = 0
) (
  input  logic        tx_clk,
  input  logic        tx_resetn,
  input  logic [63:0] tx_axis_mac_tdata,
  input  logic [7:0]  tx_axis_mac_tkeep,
  input  logic        tx_axis_mac_tlast,
  input  logic        tx_axis_mac_tuser,
  input  logic        tx_axis_mac_tvalid,
  output logic        tx_axis_mac_tready,
  output logic [63:0] rx_axis_mac_tdata,
  output logic [7:0]  rx_axis_mac_tkeep,
  output logic        rx_axis_mac_tlast,
  output logic        rx_axis_mac_tuser,
  output logic        rx_axis_mac_tvalid,
  input  logic        rx_axis_mac_tready,
  output logic [3:0]  lpbk_in_fsm_dbg,
  output logic [3:0]  lpbk_out_fsm_dbg,
  output logic [31:0] lpbk_frm_cnt,
  output logic [15:0] lpbk_bad_cnt,
  output logic [15:0] lpbk_drop_cnt
);

  localparam int P = C_DEPTH_LOG2 + 1;
  localparam logic [P-1:0] DEPTH = {1'b1, {C_DEPTH_LOG2{1'b0}}};
  localparam string unused_family = C_FAMILY;

  wr_state_e    wst_q, wst_d;
  rd_state_e    rst_q, rst_d;
  logic [P-1:0] wptr_q, wptr_d, cptr_q, cptr_d;
  logic [P-1:0] rptr_q, rptr_d, wcnt_q, wcnt_d;
  logic [P-1:0] cnt_cur;
  logic         err_q, err_d, en_q, err_cur;
  logic         s1_q, s1_d, ov_q, ov_d;
  lpbk_word_t   ob_q, ob_d, wword, rdata;
  logic         full, tx_hs, we, re, s2_load, rx_hs;
  logic         ev_bad, ev_drop;

  always_comb begin
    full    = (wptr_q - rptr_q) == DEPTH;
    tx_axis_mac_tready = en_q & ((wst_q == WR_DROP) | ~full);
    tx_hs   = tx_axis_mac_tvalid & tx_axis_mac_tready;
    err_cur = ((wst_q == WR_IDLE) ? 1'b0 : err_q) | tx_axis_mac_tuser;
    cnt_cur = ((wst_q == WR_IDLE) ? '0 : wcnt_q) + P'(1);
    wword   = '{good: ~err_cur, last: tx_axis_mac_tlast,
                keep: tx_axis_mac_tkeep, data: tx_axis_mac_tdata};
    wst_d   = wst_q;
    wptr_d  = wptr_q;
    cptr_d  = cptr_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    we      = 1'b0;
    ev_bad  = 1'b0;
    ev_drop = 1'b0;
    if (tx_hs) begin
      unique case (wst_q)
        WR_IDLE, WR_RECV: begin
          we     = 1'b1;
          wptr_d = wptr_q + P'(1);
          err_d  = err_cur;
          wcnt_d = cnt_cur;
          wst_d  = WR_RECV;
          if (tx_axis_mac_tlast) begin
            wst_d  = WR_IDLE;
            ev_bad = err_cur;
            if (C_DROP_BAD != 0 && err_cur) begin
              wptr_d  = cptr_q;
              ev_drop = 1'b1;
            end else begin
              cptr_d = wptr_q + P'(1);
            end
          end else if (cnt_cur == DEPTH) begin
            // Frame can never fit: swallow the rest of it.
            wst_d = WR_DROP;
          end
        end
        WR_DROP: begin
          if (tx_axis_mac_tlast) begin
            wptr_d  = cptr_q;
            ev_drop = 1'b1;
            wst_d   = WR_IDLE;
          end
        end
        default: wst_d = WR_IDLE;
      endcase
    end
  end

  // Two-deep read-ahead: RAM read register feeds the output register.
  always_comb begin
    s2_load = s1_q & (~ov_q | rx_axis_mac_tready);
    re      = (rptr_q != cptr_q) & (~s1_q | s2_load);
    rptr_d  = rptr_q + P'(re);
    s1_d    = re | (s1_q & ~s2_load);
    rx_hs   = ov_q & rx_axis_mac_tready;
    ob_d    = ob_q;
    ov_d    = ov_q;
    if (s2_load) begin
      ob_d = rdata;
      ov_d = 1'b1;
    end else if (rx_axis_mac_tready) begin
      ov_d = 1'b0;
    end
    rst_d = ov_d ? RD_SEND : RD_IDLE;
  end

  always_ff @(posedge tx_clk or negedge tx_resetn) begin
    if (!tx_resetn) begin
      wst_q  <= WR_IDLE;
      rst_q  <= RD_IDLE;
      wptr_q <= '0;
      cptr_q <= '0;
      rptr_q <= '0;
      wcnt_q <= '0;
      err_q  <= 1'b0;
      en_q   <= 1'b0;
      s1_q   <= 1'b0;
      ov_q   <= 1'b0;
      ob_q   <= '0;
    end else begin
      wst_q  <= wst_d;
      rst_q  <= rst_d;
      wptr_q <= wptr_d;
      cptr_q <= cptr_d;
      rptr_q <= rptr_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
      en_q   <= 1'b1;
      s1_q   <= s1_d;
      ov_q   <= ov_d;
      ob_q   <= ob_d;
    end
  end

  axi_eth_lpbk_ram #(
    .AW (C_DEPTH_LOG2),
    .W  (WORD_W)
  ) u_ram (
    .clk   (tx_clk),
    .we    (we),
    .waddr (wptr_q[C_DEPTH_LOG2-1:0]),
    .wdata (wword),
    .re    (re),
    .raddr (rptr_q[C_DEPTH_LOG2-1:0]),
    .rdata (rdata)
  );

  assign rx_axis_mac_tdata  = ob_q.data;
  assign rx_axis_mac_tkeep  = ob_q.keep;
  assign rx_axis_mac_tlast  = ob_q.last;
  assign rx_axis_mac_tuser  = ob_q.last & ob_q.good;
  assign rx_axis_mac_tvalid = ov_q;
  assign lpbk_in_fsm_dbg    = {2'b00, wst_q};
  assign lpbk_out_fsm_dbg   = {2'b00, rst_q};

`ifdef AXI_ETH_LPBK_STATS_EN
  logic [31:0] frm_q, frm_d;
  logic [15:0] bad_q, bad_d, drop_q, drop_d;

  always_comb begin
    frm_d  = frm_q + 32'(rx_hs & ob_q.last & ~&frm_q);
    bad_d  = bad_q + 16'(ev_bad & ~&bad_q);
    drop_d = drop_q + 16'(ev_drop & ~&drop_q);
  end

  always_ff @(posedge tx_clk or negedge tx_resetn) begin
    if (!tx_resetn) begin
      frm_q  <= '0;
      bad_q  <= '0;
      drop_q <= '0;
    end else begin
      frm_q  <= frm_d;
      bad_q  <= bad_d;
      drop_q <= drop_d;
    end
  end

  assign lpbk_frm_cnt  = frm_q;
  assign lpbk_bad_cnt  = bad_q;
  assign lpbk_drop_cnt = drop_q;
`else
  logic unused_stats;
  assign unused_stats  = ^{rx_hs, ev_bad, ev_drop};
  assign lpbk_frm_cnt  = '0;
  assign lpbk_bad_cnt  = '0;
  assign lpbk_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_eth_mac_lpbk.sv
// Scoreboard bench for axi_eth_mac_lpbk: frames pushed as driven,
// popped and compared on each RX handshake.
module tb_axi_eth_mac_lpbk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tlast, tx_tuser, tx_tvalid, tx_tready;
  logic [63:0] rx_tdata;
  logic [7:0]  rx_tkeep;
  logic        rx_tlast, rx_tuser, rx_tvalid, rx_tready;
  logic [3:0]  in_dbg, out_dbg;
  logic [31:0] frm_cnt;
  logic [15:0] bad_cnt, drop_cnt;

  always #5 clk = ~clk;

`ifdef AXI_ETH_LPBK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  axi_eth_mac_lpbk dut (
    .tx_clk             (clk),
    .tx_resetn          (rst_n),
    .tx_axis_mac_tdata  (tx_tdata),
    .tx_axis_mac_tkeep  (tx_tkeep),
    .tx_axis_mac_tlast  (tx_tlast),
    .tx_axis_mac_tuser  (tx_tuser),
    .tx_axis_mac_tvalid (tx_tvalid),
    .tx_axis_mac_tready (tx_tready),
    .rx_axis_mac_tdata  (rx_tdata),
    .rx_axis_mac_tkeep  (rx_tkeep),
    .rx_axis_mac_tlast  (rx_tlast),
    .rx_axis_mac_tuser  (rx_tuser),
    .rx_axis_mac_tvalid (rx_tvalid),
    .rx_axis_mac_tready (rx_tready),
    .lpbk_in_fsm_dbg    (in_dbg),
    .lpbk_out_fsm_dbg   (out_dbg),
    .lpbk_frm_cnt       (frm_cnt),
    .lpbk_bad_cnt       (bad_cnt),
    .lpbk_drop_cnt      (drop_cnt)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t exp_q[$];
  beat_t hold_b;
  int    n_vec = 0;
  int    n_err = 0;
  int    exp_frm = 0;
  int    exp_bad = 0;
  int    exp_drop = 0;
  bit    stall_seen, hold_v, in_frm;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
      in_frm = 1'b0;
    end else begin
      beat_t b;
      if (tx_tvalid && !tx_tready) stall_seen = 1'b1;
      if (hold_v) begin
        chk("hold_valid", 64'(rx_tvalid), 64'd1);
        chk("hold_beat", 64'({rx_tkeep, rx_tlast, rx_tuser}),
            64'({hold_b.k, hold_b.l, hold_b.u}));
        chk("hold_data", rx_tdata, hold_b.d);
      end
      if (in_frm && rx_tready) chk("no_bubble", 64'(rx_tvalid), 64'd1);
      if (rx_tvalid && rx_tready) begin
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", 64'd1, 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk("rx_data", rx_tdata, b.d);
          chk("rx_keep", 64'(rx_tkeep), 64'(b.k));
          chk("rx_last", 64'(rx_tlast), 64'(b.l));
          if (b.l) begin
            chk("rx_user", 64'(rx_tuser), 64'(b.u));
            exp_frm++;
          end
        end
        in_frm = !rx_tlast;
      end
      hold_v = rx_tvalid && !rx_tready;
      hold_b = '{d: rx_tdata, k: rx_tkeep, l: rx_tlast, u: rx_tuser};
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic l, input logic u);
    int  w;
    bit  ok;
    w  = 0;
    ok = 1'b0;
    tx_tdata  = d;
    tx_tkeep  = k;
    tx_tlast  = l;
    tx_tuser  = u;
    tx_tvalid = 1'b1;
    while (!ok && w < 4000) begin
      @(negedge clk);
      if (tx_tready) ok = 1'b1;
      w++;
      @(posedge clk);
      #1;
    end
    tx_tvalid = 1'b0;
    if (!ok) chk("tx_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input int len, input logic [7:0] lk,
                            input int ebeat, input bit keep_it);
    bit bad;
    bad = (ebeat >= 0) && (ebeat < len);
    for (int i = 0; i < len; i++) begin
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      d = {$urandom, $urandom};
      l = (i == len - 1);
      k = l ? lk : 8'hFF;
      if (keep_it) exp_q.push_back('{d: d, k: k, l: l, u: l & ~bad});
      send_beat(d, k, l, i == ebeat);
    end
    if (keep_it && bad) exp_bad++;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);
    chk(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_frm_cnt"}, 64'(frm_cnt), STATS ? 64'(exp_frm) : 64'd0);
    chk({tag, "_bad_cnt"}, 64'(bad_cnt), STATS ? 64'(exp_bad) : 64'd0);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), STATS ? 64'(exp_drop) : 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_tready"}, 64'(tx_tready), 64'd0);
    chk({tag, "_rx_tvalid"}, 64'(rx_tvalid), 64'd0);
    chk({tag, "_rx_tdata"}, rx_tdata, 64'd0);
    chk({tag, "_rx_ctl"}, 64'({rx_tkeep, rx_tlast, rx_tuser}), 64'd0);
    chk({tag, "_dbg"}, 64'({in_dbg, out_dbg}), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    tx_tdata  = '0;
    tx_tkeep  = '0;
    tx_tlast  = 1'b0;
    tx_tuser  = 1'b0;
    tx_tvalid = 1'b0;
    rx_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk_stats("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", 64'(tx_tready), 64'd0);
    @(negedge clk);
    chk("rdy_after_edge", 64'(tx_tready), 64'd1);
    @(posedge clk);
    #1;
    rx_tready = 1'b1;

    // 8-beat good frame and its replay latency
    send_frame(8, 8'hFF, -1, 1'b1);
    @(negedge clk);
    chk("lat_edge0", 64'(rx_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_edge1", 64'(rx_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_edge2", 64'(rx_tvalid), 64'd1);
    drain("good_drain");
    chk_stats("good");

    // errored frame is replayed with tuser low on tlast
    send_frame(10, 8'hFF, 3, 1'b1);
    drain("bad_drain");
    chk_stats("bad");

    // fill the buffer with rx stalled, then release
    rx_tready = 1'b0;
    for (int f = 0; f < 64; f++) send_frame(8, 8'hFF, -1, 1'b1);
    stall_seen = 1'b0;
    fork
      send_frame(8, 8'hFF, -1, 1'b1);
      begin
        repeat (40) @(negedge clk);
        chk("full_stall", 64'(stall_seen), 64'd1);
        @(posedge clk);
        #1;
        rx_tready = 1'b1;
      end
    join
    drain("full_drain");
    chk_stats("full");

    // oversize frame is dropped, following frame survives
    send_frame(600, 8'hFF, -1, 1'b0);
    exp_drop++;
    send_frame(8, 8'hFF, -1, 1'b1);
    drain("oversize_drain");
    chk_stats("oversize");

    // back-to-back frames with partial last keep
    for (int f = 0; f < 4; f++) send_frame(9, 8'h0F, -1, 1'b1);
    drain("b2b_drain");
    chk_stats("b2b");

    // reset mid-frame with a committed frame still buffered
    rx_tready = 1'b0;
    send_frame(8, 8'hFF, -1, 1'b0);
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    chk("recv_dbg", 64'(in_dbg), 64'd1);
    tx_tdata  = {$urandom, $urandom};
    tx_tvalid = 1'b1;
    rst_n     = 1'b0;
    exp_q.delete();
    exp_frm  = 0;
    exp_bad  = 0;
    exp_drop = 0;
    @(negedge clk);
    chk_zero("midreset");
    chk_stats("midreset");
    tx_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rx_tready = 1'b1;
    send_frame(2, 8'hFF, -1, 1'b1);
    drain("post_reset_drain");
    repeat (20) @(negedge clk);
    chk_stats("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
